decode_pipe_stage: RTL and testbench
====================================

// Module: decode_pipe_stage
// PURPOSE
//   Parametrised MIPS decode stage with an integrated D/E pipeline register.
//   Holds the register file, rs/rt forwarding, branch compare and next-PC select.
//   Adds a valid/ready handshake, stall/flush control and exception-code merging.
//   Sits between the F/D register and the E stage of the 5-stage pipeline.
// PARAMETERS
//   DATA_W    32            datapath width (GPR, PC, immediates)
//   NREG      32            number of GPRs; index 0 reads as zero
//   FWD_SRCS  4             forward sources; source 0 = GRF read, 1..N-1 from fwd_data
//   WR_BYPASS 1             1: W-stage write is visible to same-cycle reads
//   NOP_PC    32'h0000_3000 pc_e value loaded on reset and on flush
// PORTS
//   clk         in   1                   rising-edge clock
//   reset       in   1                   asynchronous, active-high
//   in_valid    in   1                   instr_d, pc_d and exc_d are valid
//   in_ready    out  1                   stage accepts the D input this cycle
//   pc_d        in   DATA_W              PC of the D instruction
//   instr_d     in   32                  D instruction word
//   exc_d       in   5                   exception code from F (0 = none)
//   w_en        in   1                   GRF write enable from W stage
//   w_addr      in   log2(NREG)          GRF write index
//   w_data      in   DATA_W              GRF write data
//   fwd_data    in   (FWD_SRCS-1)*DATA_W packed forward values, source 1 in the LSBs
//   fwd_sel_rs  in   log2(FWD_SRCS)      forward select for rs (from hazard unit)
//   fwd_sel_rt  in   log2(FWD_SRCS)      forward select for rt
//   stall       in   1                   hazard stall: hold D, send a bubble to E
//   flush       in   1                   kill the D/E content, e.g. exception or eret
//   out_valid   out  1                   E-side register holds a real instruction
//   out_ready   in   1                   E stage can accept
//   instr_e     out  32                  registered instruction
//   pc_e        out  DATA_W              registered PC
//   rs_e, rt_e  out  DATA_W              registered operands, after forwarding
//   ext_e       out  DATA_W              registered extended immediate
//   exc_e       out  5                   registered merged exception code
//   npc         out  DATA_W              branch/jump target (combinational)
//   npc_take    out  1                   redirect F to npc this cycle
//   eret_d      out  1                   D instruction is eret (combinational)
// BEHAVIOUR
//   - Reset, asynchronous:
//     - GRF is all zero.
//     - out_valid=0, instr_e=0, pc_e=NOP_PC, rs_e/rt_e/ext_e=0, exc_e=0.
//   - Handshake: in_ready = !stall & (out_ready | !out_valid).
//   - Register update on each clk edge, first matching rule wins:
//     - flush: load a bubble (out_valid=0, instr_e=0, exc_e=0, pc_e=NOP_PC).
//     - in_valid & in_ready: capture the D input; out_valid=1. Latency is 1 cycle.
//     - stall & out_ready: load a bubble.
//     - otherwise: hold (E is back-pressured).
//   - GRF:
//     - A write is committed on the clk edge when w_en & w_addr!=0.
//     - A write to index 0 is dropped.
//     - WR_BYPASS=1: a read whose index equals w_addr (nonzero) while w_en=1 returns w_data.
//   - Operands: sel 0 takes the GRF read; sel k takes fwd_data slice k-1.
//     Forwarded values feed both the compare logic and rs_e/rt_e.
//   - Exception merge:
//     - exc_d!=0 passes through unchanged.
//     - Otherwise an illegal opcode/funct gives 5'd10 (RI); else 0.
//   - Ext: zero-extend for andi/ori/xori; lui puts imm in [31:16]; otherwise sign-extend.
//   - npc and npc_take:
//     - Branches (beq/bne/blez/bgtz/bltz/bgez): npc = pc_d+4+(sext(imm)<<2).
//     - j/jal: npc = {pc_d+4[31:28], imm26, 2'b00}.
//     - jr/jalr: npc = forwarded rs.
//     - npc_take = in_valid & !stall & !flush & (branch condition true | jump).
//     - While stall=1, npc_take=0 and the comparison is recomputed each cycle.
//   - Simultaneous flush and stall: flush wins.
//   - reset asserted mid-operation: immediate return to reset values; no partial write lands.
//   - Compare semantics: signed compares for blez/bgtz/bltz/bgez; equality only for beq/bne.
// STRUCTURE
//   - Package decode_pkg holds:
//     - opcode/funct localparams
//     - ExcCode constants (RI=10)
//     - the ext_op_t and npc_sel_t enums
//   - One sub-module, decode_ctrl (combinational): instr -> npc_sel, ext_op, legal, eret.
//   - The GRF array, forwarding muxes, compare logic and D/E register stay inline.
// TESTING
//   - Reset mid-run:
//     - Stimulus: assert reset while out_valid=1 and GRF[5]=0x1234.
//     - Response: out_valid=0, pc_e=0x3000, GRF[5]=0 with no clk edge.
//   - Write bypass:
//     - Stimulus: w_en=1, w_addr=8, w_data=0xCAFE, instr_d=addu $9,$8,$0, same cycle.
//     - Response: rs_e=0xCAFE the next cycle. A write to $0 then reads back as 0.
//   - Forwarded branch:
//     - Stimulus: beq $3,$4,+4 at pc_d=0x3010, fwd_sel_rs=1 (value 7), GRF[4]=7.
//     - Response: npc_take=1, npc=0x3024.
//   - Stall then release:
//     - Stimulus: stall=1 for 2 cycles, then 0.
//     - Response: in_ready=0; two bubbles with out_valid=0; npc_take=0;
//       then the instruction is captured once.
//   - Flush and exceptions:
//     - Stimulus: flush and stall high together.
//     - Response: bubble.
//     - Stimulus: illegal opcode 0x3F with exc_d=0.
//     - Response: exc_e=10.
//     - Stimulus: exc_d=4 with an illegal opcode.
//     - Response: exc_e=4.
//   - Back-pressure:
//     - Stimulus: out_ready=0 with out_valid=1.
//     - Response: all *_e outputs hold and in_ready=0.

Source files
------------

// File: rtl/decode_pkg.sv
// decode_pkg: opcode/funct encodings, exception codes and decode enums for the D stage
package decode_pkg;
  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J = 6'h02, OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ = 6'h07;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0a, OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI = 6'h0c, OP_ORI = 6'h0d, OP_XORI = 6'h0e, OP_LUI = 6'h0f;
  localparam logic [5:0] OP_COP0 = 6'h10;
  localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23, OP_LBU = 6'h24, OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2b;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06, F_SRAV = 6'h07, F_JR = 6'h08, F_JALR = 6'h09;
  localparam logic [5:0] F_SYSCALL = 6'h0c, F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12;
  localparam logic [5:0] F_MTLO = 6'h13, F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1a;
  localparam logic [5:0] F_DIVU = 6'h1b, F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23, F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26;
  localparam logic [5:0] F_NOR = 6'h27, F_SLT = 6'h2a, F_SLTU = 6'h2b;
  localparam logic [4:0] RS_MFC0 = 5'd0, RS_MTC0 = 5'd4;
  localparam logic [31:0] ERET_WORD = 32'h4200_0018;
  localparam logic [4:0] EXC_NONE = 5'd0, EXC_RI = 5'd10;
  typedef enum logic [1:0] {EXT_SIGN, EXT_ZERO, EXT_LUI} ext_op_t;
  typedef enum logic [3:0] {
    NPC_NONE, NPC_BEQ, NPC_BNE, NPC_BLEZ, NPC_BGTZ, NPC_BLTZ, NPC_BGEZ, NPC_J, NPC_JR
  } npc_sel_t;
  function automatic logic funct_legal(input logic [5:0] f);
    case (f)
      F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV, F_JR, F_JALR, F_SYSCALL,
      F_MFHI, F_MTHI, F_MFLO, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU,
      F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/decode_pipe_stage_ctrl.sv
// decode_ctrl: combinational instruction classifier
//   instr_i   : D instruction word
//   npc_sel_o : branch/jump kind, ext_op_o : immediate extension mode
//   legal_o   : opcode/funct recognised, eret_o : instruction is eret
module decode_ctrl
  import decode_pkg::*;
(
  input  logic [31:0] instr_i,
  output npc_sel_t    npc_sel_o,
  output ext_op_t     ext_op_o,
  output logic        legal_o,
  output logic        eret_o
);
  logic [5:0] op, funct;
  logic [4:0] rs, rt;
  assign op = instr_i[31:26];
  assign rs = instr_i[25:21];
  assign rt = instr_i[20:16];
  assign funct = instr_i[5:0];
  always_comb begin
    npc_sel_o = NPC_NONE;
    ext_op_o = EXT_SIGN;
    legal_o = 1'b1;
    eret_o = 1'b0;
    case (op)
      OP_SPECIAL: begin
        legal_o = funct_legal(funct);
        npc_sel_o = (funct == F_JR || funct == F_JALR) ? NPC_JR : NPC_NONE;
      end
      OP_REGIMM: begin
        legal_o = rt[4:1] == 4'd0;
        npc_sel_o = rt == 5'd0 ? NPC_BLTZ : rt == 5'd1 ? NPC_BGEZ : NPC_NONE;
      end
      OP_J, OP_JAL: npc_sel_o = NPC_J;
      OP_BEQ: npc_sel_o = NPC_BEQ;
      OP_BNE: npc_sel_o = NPC_BNE;
      OP_BLEZ: npc_sel_o = NPC_BLEZ;
      OP_BGTZ: npc_sel_o = NPC_BGTZ;
      OP_ANDI, OP_ORI, OP_XORI: ext_op_o = EXT_ZERO;
      OP_LUI: ext_op_o = EXT_LUI;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
      OP_SB, OP_SH, OP_SW: legal_o = 1'b1;
      OP_COP0: begin
        eret_o = instr_i == ERET_WORD;
        legal_o = instr_i == ERET_WORD || rs == RS_MFC0 || rs == RS_MTC0;
      end
      default: legal_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/decode_pipe_stage.sv
// decode_pipe_stage: MIPS decode stage with GRF, forwarding, branch resolve and D/E register
//   D side : in_valid/in_ready, pc_d, instr_d, exc_d, stall, flush
//   W side : w_en, w_addr, w_data (GRF write port)
//   Fwd    : fwd_data (source 1 in LSBs), fwd_sel_rs, fwd_sel_rt (0 = GRF read)
//   E side : out_valid/out_ready, instr_e, pc_e, rs_e, rt_e, ext_e, exc_e
//   F side : npc, npc_take, eret_d (combinational)
module decode_pipe_stage
  import decode_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREG = 32,
  parameter int FWD_SRCS = 4,
  parameter int WR_BYPASS = 1,
  parameter logic [DATA_W-1:0] NOP_PC = 'h0000_3000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            pc_d,
  input  logic [31:0]                  instr_d,
  input  logic [4:0]                   exc_d,
  input  logic                         w_en,
  input  logic [$clog2(NREG)-1:0]      w_addr,
  input  logic [DATA_W-1:0]            w_data,
  input  logic [(FWD_SRCS-1)*DATA_W-1:0] fwd_data,
  input  logic [$clog2(FWD_SRCS)-1:0]  fwd_sel_rs,
  input  logic [$clog2(FWD_SRCS)-1:0]  fwd_sel_rt,
  input  logic                         stall,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  instr_e,
  output logic [DATA_W-1:0]            pc_e,
  output logic [DATA_W-1:0]            rs_e,
  output logic [DATA_W-1:0]            rt_e,
  output logic [DATA_W-1:0]            ext_e,
  output logic [4:0]                   exc_e,
  output logic [DATA_W-1:0]            npc,
  output logic                         npc_take,
  output logic                         eret_d
);
  localparam int AW = $clog2(NREG);
  npc_sel_t npc_sel;
  ext_op_t ext_op;
  logic legal, eq, neg, zero, cond, cap;
  logic [AW-1:0] rs_a, rt_a;
  logic [DATA_W-1:0] grf_q [NREG];
  logic [DATA_W-1:0] src_rs [FWD_SRCS];
  logic [DATA_W-1:0] src_rt [FWD_SRCS];
  logic [DATA_W-1:0] rs_v, rt_v, ext_v, pc4, bt;
  logic valid_e_q, valid_e_d;
  logic [31:0] instr_e_q, instr_e_d;
  logic [DATA_W-1:0] pc_e_q, pc_e_d, rs_e_q, rs_e_d, rt_e_q, rt_e_d, ext_e_q, ext_e_d;
  logic [4:0] exc_e_q, exc_e_d, exc_m;
  decode_ctrl u_ctrl (
    .instr_i  (instr_d),
    .npc_sel_o(npc_sel),
    .ext_op_o (ext_op),
    .legal_o  (legal),
    .eret_o   (eret_d)
  );
  assign rs_a = AW'(instr_d[25:21]);
  assign rt_a = AW'(instr_d[20:16]);
  always_ff @(posedge clk or posedge reset)
    if (reset) for (int i = 0; i < NREG; i++) grf_q[i] <= '0;
    else if (w_en && w_addr != '0) grf_q[w_addr] <= w_data;
  always_comb begin
    src_rs[0] = rs_a == '0 ? '0 : (WR_BYPASS != 0 && w_en && w_addr == rs_a) ? w_data : grf_q[rs_a];
    src_rt[0] = rt_a == '0 ? '0 : (WR_BYPASS != 0 && w_en && w_addr == rt_a) ? w_data : grf_q[rt_a];
    for (int k = 1; k < FWD_SRCS; k++) begin
      src_rs[k] = fwd_data[(k-1)*DATA_W +: DATA_W];
      src_rt[k] = fwd_data[(k-1)*DATA_W +: DATA_W];
    end
  end
  assign rs_v = src_rs[fwd_sel_rs];
  assign rt_v = src_rt[fwd_sel_rt];
  assign ext_v = ext_op == EXT_ZERO ? DATA_W'(instr_d[15:0]) :
                 ext_op == EXT_LUI ? DATA_W'({instr_d[15:0], 16'h0000}) :
                 {{(DATA_W-16){instr_d[15]}}, instr_d[15:0]};
  assign exc_m = exc_d != EXC_NONE ? exc_d : legal ? EXC_NONE : EXC_RI;
  assign pc4 = pc_d + DATA_W'(4);
  assign bt = pc4 + {{(DATA_W-18){instr_d[15]}}, instr_d[15:0], 2'b00};
  assign npc = npc_sel == NPC_J ? {pc4[DATA_W-1:28], instr_d[25:0], 2'b00} :
               npc_sel == NPC_JR ? rs_v : bt;
  // sign bit and zero test give the signed compares against 0 directly
  assign eq = rs_v == rt_v;
  assign neg = rs_v[DATA_W-1];
  assign zero = rs_v == '0;
  assign cond = (npc_sel == NPC_BEQ && eq) || (npc_sel == NPC_BNE && !eq) ||
                (npc_sel == NPC_BLEZ && (neg || zero)) || (npc_sel == NPC_BGTZ && !neg && !zero) ||
                (npc_sel == NPC_BLTZ && neg) || (npc_sel == NPC_BGEZ && !neg) ||
                npc_sel == NPC_J || npc_sel == NPC_JR;
  assign npc_take = in_valid && !stall && !flush && cond;
  assign in_ready = !stall && (out_ready || !valid_e_q);
  assign cap = in_valid && in_ready;
  always_comb begin
    valid_e_d = valid_e_q;
    instr_e_d = instr_e_q;
    pc_e_d = pc_e_q;
    rs_e_d = rs_e_q;
    rt_e_d = rt_e_q;
    ext_e_d = ext_e_q;
    exc_e_d = exc_e_q;
    if (flush || (!cap && stall && out_ready)) begin
      valid_e_d = 1'b0;
      instr_e_d = '0;
      pc_e_d = NOP_PC;
      rs_e_d = '0;
      rt_e_d = '0;
      ext_e_d = '0;
      exc_e_d = EXC_NONE;
    end else if (cap) begin
      valid_e_d = 1'b1;
      instr_e_d = instr_d;
      pc_e_d = pc_d;
      rs_e_d = rs_v;
      rt_e_d = rt_v;
      ext_e_d = ext_v;
      exc_e_d = exc_m;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      valid_e_q <= 1'b0;
      instr_e_q <= '0;
      pc_e_q <= NOP_PC;
      rs_e_q <= '0;
      rt_e_q <= '0;
      ext_e_q <= '0;
      exc_e_q <= EXC_NONE;
    end else begin
      valid_e_q <= valid_e_d;
      instr_e_q <= instr_e_d;
      pc_e_q <= pc_e_d;
      rs_e_q <= rs_e_d;
      rt_e_q <= rt_e_d;
      ext_e_q <= ext_e_d;
      exc_e_q <= exc_e_d;
    end
  assign out_valid = valid_e_q;
  assign instr_e = instr_e_q;
  assign pc_e = pc_e_q;
  assign rs_e = rs_e_q;
  assign rt_e = rt_e_q;
  assign ext_e = ext_e_q;
  assign exc_e = exc_e_q;
endmodule

// File: tb/tb_decode_pipe_stage.sv
// tb_decode_pipe_stage: directed vector table plus multi-cycle sequences for decode_pipe_stage
module tb_decode_pipe_stage;
  logic clk = 1'b0, reset = 1'b1;
  logic in_valid = 1'b0, in_ready, w_en = 1'b0, stall = 1'b0, flush = 1'b0, out_ready = 1'b1;
  logic out_valid, npc_take, eret_d;
  logic [31:0] pc_d = '0, instr_d = '0, w_data = '0, instr_e, pc_e, rs_e, rt_e, ext_e, npc;
  logic [4:0] exc_d = '0, w_addr = '0, exc_e;
  logic [95:0] fwd_data = {32'hFFFF_FFFF, 32'h0000_0055, 32'h0000_0007};
  logic [1:0] fwd_sel_rs = '0, fwd_sel_rt = '0;
  int n_chk = 0, n_err = 0;

  decode_pipe_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .pc_d(pc_d),
    .instr_d(instr_d), .exc_d(exc_d), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .fwd_data(fwd_data), .fwd_sel_rs(fwd_sel_rs), .fwd_sel_rt(fwd_sel_rt), .stall(stall),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .instr_e(instr_e),
    .pc_e(pc_e), .rs_e(rs_e), .rt_e(rt_e), .ext_e(ext_e), .exc_e(exc_e), .npc(npc),
    .npc_take(npc_take), .eret_d(eret_d)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr, pc;
    logic [4:0]  exc;
    logic [1:0]  srs, srt;
    logic        take;
    logic [31:0] npc, rs, rt, ext;
    logic [4:0]  exc_e;
    logic        eret;
  } vec_t;
  vec_t v[17];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    w_en = 1'b1; w_addr = a; w_data = d;
    step();
    w_en = 1'b0;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic [1:0] srs, input logic [1:0] srt);
    in_valid = 1'b1; instr_d = ins; pc_d = pc; fwd_sel_rs = srs; fwd_sel_rt = srt;
  endtask

  initial begin
    //        instr          pc            exc srs srt take npc           rs            rt            ext           exc_e eret
    v[0]  = '{32'h1064_0004, 32'h0000_3010, 0, 1, 0, 1, 32'h0000_3024, 32'h7,        32'h7,        32'h4,        0,  0};
    v[1]  = '{32'h1064_0004, 32'h0000_3010, 0, 2, 0, 0, 32'h0,         32'h55,       32'h7,        32'h4,        0,  0};
    v[2]  = '{32'h1464_FFFE, 32'h0000_3020, 0, 2, 0, 1, 32'h0000_301C, 32'h55,       32'h7,        32'hFFFF_FFFE, 0, 0};
    v[3]  = '{32'h18C0_0008, 32'h0000_3000, 0, 0, 0, 1, 32'h0000_3024, 32'hFFFF_FFFD, 32'h0,       32'h8,        0,  0};
    v[4]  = '{32'h1CC0_0008, 32'h0000_3000, 0, 0, 0, 0, 32'h0,         32'hFFFF_FFFD, 32'h0,       32'h8,        0,  0};
    v[5]  = '{32'h0460_0010, 32'h0000_3100, 0, 3, 0, 1, 32'h0000_3144, 32'hFFFF_FFFF, 32'h0,       32'h10,       0,  0};
    v[6]  = '{32'h0461_0010, 32'h0000_3100, 0, 0, 0, 1, 32'h0000_3144, 32'h7,        32'h0,        32'h10,       0,  0};
    v[7]  = '{32'h0800_0C40, 32'h1000_3200, 0, 0, 0, 1, 32'h1000_3100, 32'h0,        32'h0,        32'hC40,      0,  0};
    v[8]  = '{32'h00E0_0008, 32'h0000_3300, 0, 0, 0, 1, 32'h0000_0100, 32'h100,      32'h0,        32'h8,        0,  0};
    v[9]  = '{32'h3462_8000, 32'h0000_3400, 0, 0, 0, 0, 32'h0,         32'h7,        32'h0,        32'h8000,     0,  0};
    v[10] = '{32'h2062_8000, 32'h0000_3400, 0, 0, 0, 0, 32'h0,         32'h7,        32'h0,        32'hFFFF_8000, 0, 0};
    v[11] = '{32'h3C02_1234, 32'h0000_3400, 0, 0, 0, 0, 32'h0,         32'h0,        32'h0,        32'h1234_0000, 0, 0};
    v[12] = '{32'hFC00_0000, 32'h0000_3500, 0, 0, 0, 0, 32'h0,         32'h0,        32'h0,        32'h0,        10, 0};
    v[13] = '{32'hFC00_0000, 32'h0000_3500, 4, 0, 0, 0, 32'h0,         32'h0,        32'h0,        32'h0,        4,  0};
    v[14] = '{32'h0000_003F, 32'h0000_3500, 0, 0, 0, 0, 32'h0,         32'h0,        32'h0,        32'h3F,       10, 0};
    v[15] = '{32'h0064_1021, 32'h0000_3600, 0, 0, 2, 0, 32'h0,         32'h7,        32'h55,       32'h1021,     0,  0};
    v[16] = '{32'h4200_0018, 32'h0000_3700, 0, 0, 0, 0, 32'h0,         32'h0,        32'h0,        32'h18,       0,  1};

    #12 reset = 1'b0;
    #1;
    chk("reset out_valid", out_valid, 0);
    chk("reset pc_e", pc_e, 32'h3000);
    chk("reset instr_e", instr_e, 0);
    chk("reset exc_e", exc_e, 0);
    chk("reset rs_e", rs_e, 0);
    chk("reset in_ready", in_ready, 1);
    step();
    wr(3, 32'h7); wr(4, 32'h7); wr(6, 32'hFFFF_FFFD); wr(7, 32'h100);

    for (int i = 0; i < 17; i++) begin
      drive(v[i].instr, v[i].pc, v[i].srs, v[i].srt);
      exc_d = v[i].exc;
      #1;
      chk($sformatf("v%0d npc_take", i), npc_take, v[i].take);
      if (v[i].take) chk($sformatf("v%0d npc", i), npc, v[i].npc);
      chk($sformatf("v%0d eret_d", i), eret_d, v[i].eret);
      step();
      chk($sformatf("v%0d out_valid", i), out_valid, 1);
      chk($sformatf("v%0d instr_e", i), instr_e, v[i].instr);
      chk($sformatf("v%0d pc_e", i), pc_e, v[i].pc);
      chk($sformatf("v%0d rs_e", i), rs_e, v[i].rs);
      chk($sformatf("v%0d rt_e", i), rt_e, v[i].rt);
      chk($sformatf("v%0d ext_e", i), ext_e, v[i].ext);
      chk($sformatf("v%0d exc_e", i), exc_e, v[i].exc_e);
    end
    exc_d = '0;

    w_en = 1'b1; w_addr = 8; w_data = 32'hCAFE;
    drive(32'h0100_4821, 32'h3800, 0, 0);
    step();
    chk("bypass rs_e", rs_e, 32'hCAFE);
    w_addr = 0; w_data = 32'hBEEF;
    drive(32'h0000_4821, 32'h3804, 0, 0);
    step();
    chk("zero write rs_e", rs_e, 0);
    w_en = 1'b0;
    step();
    chk("zero reread rs_e", rs_e, 0);

    stall = 1'b1;
    drive(32'h1064_0004, 32'h3010, 1, 0);
    #1;
    chk("stall in_ready", in_ready, 0);
    chk("stall npc_take", npc_take, 0);
    step();
    chk("stall bubble1 out_valid", out_valid, 0);
    chk("stall bubble1 npc_take", npc_take, 0);
    step();
    chk("stall bubble2 out_valid", out_valid, 0);
    stall = 1'b0;
    #1;
    chk("release in_ready", in_ready, 1);
    chk("release npc_take", npc_take, 1);
    chk("release npc", npc, 32'h3024);
    step();
    chk("release out_valid", out_valid, 1);
    chk("release instr_e", instr_e, 32'h1064_0004);
    chk("release pc_e", pc_e, 32'h3010);

    flush = 1'b1; stall = 1'b1;
    #1;
    chk("flush npc_take", npc_take, 0);
    step();
    chk("flush+stall out_valid", out_valid, 0);
    chk("flush+stall pc_e", pc_e, 32'h3000);
    chk("flush+stall instr_e", instr_e, 0);
    stall = 1'b0;
    drive(32'hFC00_0000, 32'h3900, 0, 0);
    step();
    chk("flush over capture out_valid", out_valid, 0);
    chk("flush over capture exc_e", exc_e, 0);
    flush = 1'b0;

    drive(32'h3462_8000, 32'h3400, 0, 0);
    step();
    chk("bp load out_valid", out_valid, 1);
    out_ready = 1'b0;
    drive(32'h3C02_1234, 32'h3500, 0, 0);
    #1;
    chk("bp in_ready", in_ready, 0);
    step();
    chk("bp hold instr_e", instr_e, 32'h3462_8000);
    chk("bp hold pc_e", pc_e, 32'h3400);
    chk("bp hold ext_e", ext_e, 32'h8000);
    chk("bp hold rs_e", rs_e, 32'h7);
    chk("bp hold out_valid", out_valid, 1);
    stall = 1'b1;
    step();
    chk("bp+stall out_valid", out_valid, 1);
    chk("bp+stall instr_e", instr_e, 32'h3462_8000);
    stall = 1'b0; out_ready = 1'b1;
    step();
    chk("bp release instr_e", instr_e, 32'h3C02_1234);
    chk("bp release pc_e", pc_e, 32'h3500);

    in_valid = 1'b0;
    wr(5, 32'h1234);
    drive(32'h00A0_0008, 32'h3600, 0, 0);
    #1;
    chk("pre-reset npc", npc, 32'h1234);
    step();
    chk("pre-reset out_valid", out_valid, 1);
    chk("pre-reset rs_e", rs_e, 32'h1234);
    #2 reset = 1'b1;
    #1;
    chk("async reset out_valid", out_valid, 0);
    chk("async reset pc_e", pc_e, 32'h3000);
    chk("async reset instr_e", instr_e, 0);
    chk("async reset rs_e", rs_e, 0);
    chk("async reset grf5", npc, 0);
    w_en = 1'b1; w_addr = 6; w_data = 32'hDEAD;
    step();
    w_en = 1'b0;
    #2 reset = 1'b0;
    drive(32'h00C0_0008, 32'h3610, 0, 0);
    #1;
    chk("reset write dropped grf6", npc, 0);
    chk("post-reset in_ready", in_ready, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
